// File: rtl/mem_arbiter.sv
// mem_arbiter: two word-sized requesters share one AXI-Lite master port, one transaction at a time.
// Build option ARB_ROUND_ROBIN_EN: round-robin tie-break; otherwise requester 0 has fixed priority.
module mem_arbiter #(
    parameter logic [2:0] PROT = 3'b000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic [1:0]  req_ready,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] axi_araddr,
    output logic        axi_arvalid,
    output logic [2:0]  axi_arprot,
    input  logic        axi_arready,
    input  logic [31:0] axi_rdata,
    input  logic [1:0]  axi_rresp,
    input  logic        axi_rvalid,
    output logic        axi_rready,
    output logic [31:0] axi_awaddr,
    output logic        axi_awvalid,
    output logic [2:0]  axi_awprot,
    input  logic        axi_awready,
    output logic [31:0] axi_wdata,
    output logic [3:0]  axi_wstrb,
    output logic        axi_wvalid,
    input  logic        axi_wready,
    input  logic [1:0]  axi_bresp,
    input  logic        axi_bvalid,
    output logic        axi_bready
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_AR  = 3'd1,
        RD_R   = 3'd2,
        WR_AWW = 3'd3,
        WR_B   = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_gnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_aw_done;
    logic        r_w_done;
    logic [1:0]  r_resp;
    logic [31:0] r_rdata;

    logic        w_gnt;
    logic        w_accept;
    logic        w_sel_we;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_r_hs;
    logic        w_b_hs;

`ifdef ARB_ROUND_ROBIN_EN
    // r_last holds the requester granted most recently; reset value 1 lets requester 0 win the first tie.
    logic r_last;

    always_comb begin
        if (req_valid == 2'b11) begin
            w_gnt = ~r_last;
        end else begin
            w_gnt = ~req_valid[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_last <= w_gnt;
        end
    end
`else
    assign w_gnt = ~req_valid[0];
`endif

    // rst gates the accept so req_ready stays low for the whole reset, not just after it settles.
    assign w_accept = (r_state == IDLE) && (|req_valid) && !rst;
    assign w_sel_we = w_gnt ? req_we[1] : req_we[0];

    assign w_aw_hs = (r_state == WR_AWW) && !r_aw_done && axi_awready;
    assign w_w_hs  = (r_state == WR_AWW) && !r_w_done && axi_wready;
    assign w_r_hs  = (r_state == RD_R) && axi_rvalid;
    assign w_b_hs  = (r_state == WR_B) && axi_bvalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        req_ready   = 2'b00;
        axi_arvalid = 1'b0;
        axi_rready  = 1'b0;
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        axi_bready  = 1'b0;
        rsp_valid   = 2'b00;
        rsp_err     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    req_ready = w_gnt ? 2'b10 : 2'b01;
                    w_next    = w_sel_we ? WR_AWW : RD_AR;
                end
            end
            RD_AR: begin
                axi_arvalid = 1'b1;
                if (axi_arready) begin
                    w_next = RD_R;
                end
            end
            RD_R: begin
                axi_rready = 1'b1;
                if (axi_rvalid) begin
                    w_next = RESP;
                end
            end
            WR_AWW: begin
                axi_awvalid = !r_aw_done;
                axi_wvalid  = !r_w_done;
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_next = WR_B;
                end
            end
            WR_B: begin
                axi_bready = 1'b1;
                if (axi_bvalid) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = r_gnt ? 2'b10 : 2'b01;
                rsp_err   = |r_resp;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_resp    <= 2'b00;
            r_rdata   <= 32'd0;
        end else begin
            if (w_accept) begin
                r_gnt     <= w_gnt;
                r_we      <= w_sel_we;
                r_addr    <= w_gnt ? req_addr[63:32] : req_addr[31:0];
                r_wdata   <= w_gnt ? req_wdata[63:32] : req_wdata[31:0];
                r_wstrb   <= w_gnt ? req_wstrb[7:4] : req_wstrb[3:0];
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_w_done <= 1'b1;
            end
            if (w_r_hs) begin
                r_rdata <= axi_rdata;
                r_resp  <= axi_rresp;
            end
            if (w_b_hs) begin
                r_resp <= axi_bresp;
            end
        end
    end

    assign axi_araddr = r_addr;
    assign axi_awaddr = r_addr;
    assign axi_wdata  = r_wdata;
    assign axi_wstrb  = r_wstrb;
    assign axi_arprot = PROT;
    assign axi_awprot = PROT;
    assign rsp_rdata  = r_rdata;

    logic w_unused;
    assign w_unused = r_we;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed test-plan steps followed by randomized transactions,
// each checked cycle by cycle against latencies derived from the handshake rules.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] axi_araddr;
    logic        axi_arvalid;
    logic [2:0]  axi_arprot;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [31:0] axi_awaddr;
    logic        axi_awvalid;
    logic [2:0]  axi_awprot;
    logic        axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arprot(axi_arprot),
        .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awprot(axi_awprot),
        .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int m_last = 1;   // model of "requester granted last"

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {req_ready[1:0], arvalid, rready, awvalid, wvalid, bready, rsp_valid[1:0]}
    function automatic logic [63:0] ctl();
        return {55'd0, req_ready, axi_arvalid, axi_rready, axi_awvalid, axi_wvalid,
                axi_bready, rsp_valid};
    endfunction

    task automatic slave_idle();
        axi_arready = 1'b0;
        axi_rvalid  = 1'b0;
        axi_rdata   = 32'd0;
        axi_rresp   = 2'b00;
        axi_awready = 1'b0;
        axi_wready  = 1'b0;
        axi_bvalid  = 1'b0;
        axi_bresp   = 2'b00;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, ctl(), 64'd0);
        chk({tag, "_bus_a"}, {axi_araddr, axi_awaddr}, 64'd0);
        chk({tag, "_bus_d"}, {axi_wdata, rsp_rdata}, 64'd0);
        chk({tag, "_misc"}, {53'd0, axi_wstrb, rsp_err, axi_arprot, axi_awprot}, 64'd0);
    endtask

    // Read: d1 = AR wait, d2 = R wait. Write: d1 = AW wait, d2 = W wait, d3 = B wait.
    // rst_at > 0 pulses reset at that cycle after the accept and abandons the transaction.
    task automatic run_txn(input logic [1:0] vld, input logic [1:0] we,
                           input logic [63:0] addr, input logic [63:0] wd, input logic [7:0] ws,
                           input int d1, input int d2, input int d3,
                           input logic [31:0] sdata, input logic [1:0] sresp, input int rst_at);
        int gi;
        int m;
        int t_rsp;
        logic is_wr;
        logic [1:0] oh;
        logic [63:0] exp;
        if (vld == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
            gi = (m_last == 0) ? 1 : 0;
`else
            gi = 0;
`endif
        end else begin
            gi = vld[1] ? 1 : 0;
        end
        oh    = (gi == 1) ? 2'b10 : 2'b01;
        is_wr = we[gi];
        m     = (d1 > d2) ? d1 : d2;
        t_rsp = is_wr ? (3 + m + d3) : (3 + d1 + d2);

        @(negedge clk);
        slave_idle();
        req_valid = vld;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_wstrb = ws;
        #1;
        chk("accept_ready", {62'd0, req_ready}, {62'd0, oh});
        m_last = gi;

        for (int k = 1; k <= t_rsp + 1; k++) begin
            @(negedge clk);
            slave_idle();
            if (k == 1) req_valid[gi] = 1'b0;
            if (k == t_rsp) req_valid = 2'b00;
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                chk_all_zero("mid_rst");
                req_valid = 2'b00;
                @(negedge clk);
                rst = 1'b0;
                m_last = 1;
                return;
            end
            exp = 64'd0;
            if (!is_wr) begin
                exp[6] = (k <= 1 + d1);
                exp[5] = (k >= 2 + d1) && (k <= 2 + d1 + d2);
                axi_arready = (k == 1 + d1);
                axi_rvalid  = (k == 2 + d1 + d2);
                if (axi_rvalid) begin
                    axi_rdata = sdata;
                    axi_rresp = sresp;
                end
            end else begin
                exp[4] = (k <= 1 + d1);
                exp[3] = (k <= 1 + d2);
                exp[2] = (k >= 2 + m) && (k <= 2 + m + d3);
                axi_awready = (k == 1 + d1);
                axi_wready  = (k == 1 + d2);
                axi_bvalid  = (k == 2 + m + d3);
                if (axi_bvalid) axi_bresp = sresp;
            end
            if (k == t_rsp) exp[1:0] = oh;
            #1;
            chk("ctl", ctl(), exp);
            if (k == 1) begin
                if (is_wr) begin
                    chk("aw_w_bus", {axi_awaddr, axi_wdata}, {addr[32*gi +: 32], wd[32*gi +: 32]});
                    chk("wstrb_prot", {57'd0, axi_wstrb, axi_awprot}, {57'd0, ws[4*gi +: 4], 3'b000});
                end else begin
                    chk("ar_bus", {29'd0, axi_arprot, axi_araddr}, {32'd0, addr[32*gi +: 32]});
                end
            end
            if (k == t_rsp) begin
                chk("rsp_err", {63'd0, rsp_err}, {63'd0, (sresp != 2'b00)});
                if (!is_wr) chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, sdata});
            end
        end
    endtask

    initial begin
        logic [1:0]  v;
        logic [1:0]  w;
        logic [1:0]  r;
        logic [7:0]  s;
        rst       = 1'b1;
        req_valid = 2'b11;
        req_we    = 2'b00;
        req_addr  = 64'd0;
        req_wdata = 64'd0;
        req_wstrb = 8'd0;
        slave_idle();
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b0;

        // zero-wait read from requester 0
        run_txn(2'b01, 2'b00, {32'd0, 32'h0000_1000}, 64'd0, 8'd0, 0, 0, 0,
                32'hDEAD_BEEF, 2'b00, 0);
        // write from requester 1, AW delayed 2, SLVERR
        run_txn(2'b10, 2'b10, {32'h0000_0010, 32'd0}, {32'h1234_5678, 32'd0}, 8'h30, 2, 0, 0,
                32'd0, 2'b10, 0);
        // both continuously requesting
        repeat (4) run_txn(2'b11, 2'b00, {32'h0000_2000, 32'h0000_1000}, 64'd0, 8'd0, 0, 0, 0,
                           $urandom, 2'b00, 0);
        // rvalid delayed 5 cycles
        run_txn(2'b01, 2'b00, {32'd0, 32'h0000_0040}, 64'd0, 8'd0, 0, 5, 0,
                32'hCAFE_F00D, 2'b00, 0);
        // reset while waiting in WR_B (B wait 3, reset at cycle 3)
        run_txn(2'b01, 2'b01, {32'd0, 32'h0000_0080}, {32'd0, 32'hA5A5_5A5A}, 8'h0F, 0, 0, 3,
                32'd0, 2'b00, 3);
        #1;
        chk_all_zero("post_rst");
        run_txn(2'b11, 2'b00, {32'h0000_0300, 32'h0000_0200}, 64'd0, 8'd0, 1, 1, 0,
                32'h0BAD_F00D, 2'b00, 0);
        // zero strobe write still issued
        run_txn(2'b10, 2'b11, {32'h0000_0400, 32'd0}, {32'h5555_AAAA, 32'd0}, 8'h00, 0, 3, 1,
                32'd0, 2'b00, 0);

        for (int i = 0; i < 60; i++) begin
            v = 2'($urandom_range(1, 3));
            w = 2'($urandom);
            r = 2'($urandom);
            s = 8'($urandom);
            run_txn(v, w, {$urandom, $urandom}, {$urandom, $urandom}, s,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom, r, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
